// File: rtl/correlator_pkg.sv
// Shared types and sizing helpers for the correlator counter bank and its readout.
// Latency: n/a (package).
// Backpressure: n/a (package).
package correlator_pkg;

  // Default frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Width of the serializer byte counter; covers up to 4 bytes per word (RESOLUTION <= 32).
  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_HDR,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_SUM
  } state_e;

  function automatic int num_correlators(input int n);
    return n * (n - 1) / 2;
  endfunction

  function automatic int num_words(input int n);
    return n + num_correlators(n);
  endfunction

  function automatic int word_bytes(input int res);
    return (res + 7) / 8;
  endfunction

  // Shadow-bank address of the pair counter for inputs i<j; pairs follow the per-input counts.
  function automatic int pair_index(input int n, input int i, input int j);
    return n + i * (2 * n - i - 1) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/readout_byte_serializer.sv
// Holds one loaded item (1..WORD_BYTES bytes) and shifts it out MSB first, XOR-accumulating a checksum.
// Latency: first byte valid the cycle after load_i; one byte per accepted handshake.
// Backpressure: tx_data_o/tx_valid_o held until tx_ready_i; done_o pulses on acceptance of the last byte.
module readout_byte_serializer
  import correlator_pkg::*;
#(
  parameter int WORD_BYTES = 2,
  localparam int WB = WORD_BYTES * 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WB-1:0]    load_dat_i,
  input  logic [CNT_W-1:0] load_len_i,
  input  logic             load_sum_i,
  input  logic             sum_en_i,
  input  logic             clr_sum_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             done_o
);

  logic [WB-1:0]    word_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;
  logic             sum_en_q;
  logic [7:0]       csum_q;
  logic [7:0]       csum_acc;
  logic [7:0]       csum_d;
  logic [WB-1:0]    load_word;
  logic             accept;

  assign tx_data_o  = word_q[WB-1 -: 8];
  assign tx_valid_o = valid_q;
  assign accept     = valid_q & tx_ready_i;
  assign done_o     = accept & (cnt_q == CNT_W'(1));

  // Checksum folds in the byte leaving this cycle, so a checksum load sees the final payload byte.
  always_comb begin
    csum_acc = csum_q;
    if (accept && sum_en_q) begin
      csum_acc = csum_q ^ tx_data_o;
    end
    csum_d    = clr_sum_i ? 8'h00 : csum_acc;
    load_word = load_sum_i ? (WB'(csum_acc) << (WB - 8)) : load_dat_i;
  end

  // Load takes priority over shifting; the controller only loads when empty or on the last accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q   <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      sum_en_q <= 1'b0;
      csum_q   <= 8'h00;
    end else begin
      if (load_i) begin
        word_q   <= load_word;
        cnt_q    <= load_len_i;
        valid_q  <= 1'b1;
        sum_en_q <= sum_en_i;
      end else if (accept) begin
        word_q <= word_q << 8;
        cnt_q  <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          valid_q <= 1'b0;
        end
      end
      csum_q <= csum_d;
    end
  end

endmodule

// File: rtl/correlator_readout_scheduler.sv
// Per integration tick: snapshot counters, then stream sync, sequence, every counter word and an XOR checksum.
// Latency: tick -> snapshot next cycle -> first tx_valid the cycle after (2 cycles).
// Backpressure: bytes wait indefinitely on tx_ready_i; ticks arriving while busy are dropped and counted.
module correlator_readout_scheduler
  import correlator_pkg::*;
#(
  parameter int         NUM_INPUTS = 12,
  parameter int         RESOLUTION = 16,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  localparam int        NUM_WORDS  = num_words(NUM_INPUTS),
  localparam int        WORD_BYTES = word_bytes(RESOLUTION),
  localparam int        AW         = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tick_i,
  output logic                  snapshot_o,
  output logic [AW-1:0]         rd_addr_o,
  output logic                  rd_en_o,
  input  logic [RESOLUTION-1:0] rd_data_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic [7:0]            overruns_o
);

  localparam int            WB        = WORD_BYTES * 8;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    rd_addr_q;
  logic             hdr_q;      // 0: sync byte in flight, 1: sequence byte in flight
  logic [7:0]       seq_q;
  logic [7:0]       ovr_q;

  logic             ser_load;
  logic [WB-1:0]    ser_dat;
  logic [CNT_W-1:0] ser_len;
  logic             ser_sum;
  logic             ser_sum_en;
  logic             ser_clr;
  logic             ser_done;
  logic             last_word;

  assign last_word  = (rd_addr_q == LAST_ADDR);
  assign rd_addr_o  = rd_addr_q;
  assign overruns_o = ovr_q;

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame sequencing: header, then fetch/wait/send per word, then checksum.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (tick_i) state_d = ST_SNAP;
      ST_SNAP:  state_d = ST_HDR;
      ST_HDR:   if (ser_done && hdr_q) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_SEND;
      ST_SEND:  if (ser_done) state_d = last_word ? ST_SUM : ST_FETCH;
      ST_SUM:   if (ser_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes and serializer loads decoded from the current state.
  always_comb begin
    snapshot_o = (state_q == ST_SNAP);
    busy_o     = (state_q != ST_IDLE);
    rd_en_o    = (state_q == ST_FETCH);
    ser_load   = 1'b0;
    ser_dat    = '0;
    ser_len    = CNT_W'(1);
    ser_sum    = 1'b0;
    ser_sum_en = 1'b0;
    ser_clr    = 1'b0;
    unique case (state_q)
      ST_SNAP: begin
        // Sync byte is excluded from the checksum, which restarts here.
        ser_load = 1'b1;
        ser_dat  = WB'(SYNC_BYTE) << (WB - 8);
        ser_clr  = 1'b1;
      end
      ST_HDR: begin
        if (ser_done && !hdr_q) begin
          ser_load   = 1'b1;
          ser_dat    = WB'(seq_q) << (WB - 8);
          ser_sum_en = 1'b1;
        end
      end
      ST_WAIT: begin
        // rd_data_i is valid exactly one cycle after rd_en_o, i.e. now.
        ser_load   = 1'b1;
        ser_dat    = WB'(rd_data_i);
        ser_len    = CNT_W'(WORD_BYTES);
        ser_sum_en = 1'b1;
      end
      ST_SEND: begin
        if (ser_done && last_word) begin
          ser_load = 1'b1;
          ser_sum  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Address walk, header phase, frame sequence number and saturating overrun count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_addr_q <= '0;
      hdr_q     <= 1'b0;
      seq_q     <= 8'h00;
      ovr_q     <= 8'h00;
    end else begin
      if (state_q == ST_SNAP) begin
        rd_addr_q <= '0;
        hdr_q     <= 1'b0;
      end
      if (state_q == ST_HDR && ser_done && !hdr_q) begin
        hdr_q <= 1'b1;
        seq_q <= seq_q + 8'd1;
      end
      if (state_q == ST_SEND && ser_done && !last_word) begin
        rd_addr_q <= rd_addr_q + AW'(1);
      end
      if (tick_i && state_q != ST_IDLE && ovr_q != 8'hFF) begin
        ovr_q <= ovr_q + 8'd1;
      end
    end
  end

  readout_byte_serializer #(
    .WORD_BYTES(WORD_BYTES)
  ) u_ser (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (ser_load),
    .load_dat_i (ser_dat),
    .load_len_i (ser_len),
    .load_sum_i (ser_sum),
    .sum_en_i   (ser_sum_en),
    .clr_sum_i  (ser_clr),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .done_o     (ser_done)
  );

endmodule

// File: tb/tb_correlator_readout_scheduler.sv
// Bench for the correlator readout scheduler: reference frame model plus directed scenarios.
// Latency: n/a (testbench).
// Backpressure: tx_ready driven always-on, 30% random stall, or held low.
module tb_correlator_readout_scheduler;

  localparam int NI  = 3;
  localparam int RES = 16;
  localparam int NW  = NI + NI * (NI - 1) / 2;
  localparam int WB  = (RES + 7) / 8;
  localparam int FB  = 2 + NW * WB + 1;
  localparam int AW  = $clog2(NW);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic tx_ready = 1'b1;
  logic [RES-1:0] rd_data = '0;
  logic snapshot, rd_en, tx_valid, busy;
  logic [AW-1:0] rd_addr;
  logic [7:0] tx_data, overruns;

  logic tx_ready2 = 1'b1;
  logic [11:0] rd_data2 = '0;
  logic snapshot2, rd_en2, tx_valid2, busy2;
  logic [AW-1:0] rd_addr2;
  logic [7:0] tx_data2, overruns2;

  always #5 clk = ~clk;

  correlator_readout_scheduler #(.NUM_INPUTS(NI), .RESOLUTION(RES)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .snapshot_o(snapshot),
    .rd_addr_o(rd_addr), .rd_en_o(rd_en), .rd_data_i(rd_data),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .busy_o(busy), .overruns_o(overruns)
  );

  correlator_readout_scheduler #(.NUM_INPUTS(NI), .RESOLUTION(12)) u_dut12 (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .snapshot_o(snapshot2),
    .rd_addr_o(rd_addr2), .rd_en_o(rd_en2), .rd_data_i(rd_data2),
    .tx_data_o(tx_data2), .tx_valid_o(tx_valid2), .tx_ready_i(tx_ready2),
    .busy_o(busy2), .overruns_o(overruns2)
  );

  // Shadow bank models: data only valid the cycle after rd_en, garbage otherwise.
  always @(posedge clk) begin
    rd_data  <= rd_en  ? RES'(rd_addr * 257) : 16'hDEAD;
    rd_data2 <= rd_en2 ? 12'hABC : 12'h555;
  end

  int checks = 0;
  int failures = 0;
  int rmode = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready pattern: 0 = always ready, 1 = ~30% stall, 2 = held low.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom_range(0, 99) >= 30);
      default: tx_ready = 1'b0;
    endcase
  end

  // Reference model: expected byte stream, busy window, overrun count.
  logic [7:0] exp_q[$];
  logic [7:0] acc_log[$];
  logic [7:0] q12[$];
  logic [7:0] m_seq = 8'h00;
  logic [7:0] m_ovr = 8'h00;
  bit m_active = 1'b0;
  bit was_active;
  int m_left = 0;
  int snap_cnt = 0;

  function automatic void push_frame(input logic [7:0] s);
    logic [7:0] cs, by;
    logic [31:0] val;
    exp_q.push_back(8'hA5);
    exp_q.push_back(s);
    cs = s;
    for (int w = 0; w < NW; w++) begin
      val = (w * 257) & ((32'd1 << RES) - 1);
      for (int b = WB - 1; b >= 0; b--) begin
        by = 8'(val >> (8 * b));
        exp_q.push_back(by);
        cs ^= by;
      end
    end
    exp_q.push_back(cs);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_seq = 8'h00;
      m_ovr = 8'h00;
      m_active = 1'b0;
      m_left = 0;
    end else begin
      was_active = m_active;
      if (tx_valid && tx_ready) begin
        acc_log.push_back(tx_data);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (m_left > 0) m_left--;
        if (m_left == 0) m_active = 1'b0;
      end
      if (snapshot) snap_cnt++;
      if (tick) begin
        if (was_active) begin
          if (m_ovr != 8'hFF) m_ovr++;
        end else begin
          push_frame(m_seq);
          m_seq++;
          m_active = 1'b1;
          m_left = FB;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && tx_valid2 && tx_ready2 && q12.size() < 15) q12.push_back(tx_data2);
  end

  // Per-cycle comparison against the model, away from the active edge.
  bit p_v = 1'b0, p_r = 1'b0, p_s = 1'b0;
  logic [7:0] p_d = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("busy", busy, m_active);
      check_eq("overruns", overruns, m_ovr);
      check_eq("rd_addr_range", rd_addr < NW, 1);
      if (rd_en) check_eq("rd_en_only_in_frame", busy, 1);
      if (snapshot) check_eq("snapshot_single_cycle", p_s, 0);
      if (tx_valid) begin
        check_eq("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_eq("tx_data", tx_data, exp_q[0]);
      end
      if (p_v && !p_r) begin
        check_eq("hold_valid", tx_valid, 1);
        check_eq("hold_data", tx_data, p_d);
      end
      p_v = tx_valid;
      p_r = tx_ready;
      p_d = tx_data;
      p_s = snapshot;
    end else begin
      p_v = 1'b0;
      p_s = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((busy || m_active) && n < maxc) begin
      step();
      n++;
    end
    check_eq("idle_timeout", busy, 0);
  endtask

  logic [7:0] lit1 [15] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02,
                            8'h03, 8'h03, 8'h04, 8'h04, 8'h05, 8'h05, 8'h00};

  initial begin
    int s0;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_snapshot", snapshot, 0);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overruns", overruns, 0);
    check_eq("rst_rd_en", rd_en, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_tx_data", tx_data, 0);
    rst_n = 1'b1;
    step();
    step();

    // Frame 1: latency and full literal byte stream.
    acc_log.delete();
    pulse_tick();
    check_eq("lat_snapshot", snapshot, 1);
    check_eq("lat_no_valid_yet", tx_valid, 0);
    step();
    check_eq("lat_snapshot_off", snapshot, 0);
    check_eq("lat_valid", tx_valid, 1);
    check_eq("lat_sync", tx_data, 8'hA5);
    wait_idle(500);
    check_eq("f1_len", acc_log.size(), 15);
    if (acc_log.size() == 15)
      for (int i = 0; i < 15; i++) check_eq("f1_byte", acc_log[i], lit1[i]);

    // Frame 2 under random backpressure.
    rmode = 1;
    acc_log.delete();
    s0 = snap_cnt;
    pulse_tick();
    wait_idle(3000);
    rmode = 0;
    check_eq("f2_len", acc_log.size(), 15);
    if (acc_log.size() == 15) begin
      check_eq("f2_seq", acc_log[1], 8'h01);
      check_eq("f2_sum", acc_log[14], 8'h01);
    end
    check_eq("f2_snaps", snap_cnt - s0, 1);
    step();

    // Back-to-back frames.
    acc_log.delete();
    s0 = snap_cnt;
    pulse_tick();
    wait_idle(500);
    pulse_tick();
    wait_idle(500);
    check_eq("b2b_len", acc_log.size(), 30);
    if (acc_log.size() == 30) begin
      check_eq("b2b_seq_a", acc_log[1], 8'h02);
      check_eq("b2b_sum_a", acc_log[14], 8'h02);
      check_eq("b2b_sync_b", acc_log[15], 8'hA5);
      check_eq("b2b_seq_b", acc_log[16], 8'h03);
      check_eq("b2b_sum_b", acc_log[29], 8'h03);
    end
    check_eq("b2b_snaps", snap_cnt - s0, 2);

    // Three ticks during a frame.
    s0 = snap_cnt;
    pulse_tick();
    step();
    step();
    repeat (3) begin
      check_eq("busy_before_extra_tick", busy, 1);
      pulse_tick();
      step();
    end
    wait_idle(500);
    check_eq("ovr_three", overruns, 8'd3);
    check_eq("ovr_one_snap", snap_cnt - s0, 1);

    // Saturation with the UART stalled.
    rmode = 2;
    step();
    pulse_tick();
    repeat (300) begin
      pulse_tick();
      step();
    end
    check_eq("ovr_saturate", overruns, 8'hFF);
    rmode = 0;
    wait_idle(500);

    // 12-bit instance: first frame from reset.
    check_eq("r12_len", q12.size(), 15);
    if (q12.size() == 15) begin
      check_eq("r12_sync", q12[0], 8'hA5);
      check_eq("r12_seq", q12[1], 8'h00);
      check_eq("r12_hi", q12[2], 8'h0A);
      check_eq("r12_lo", q12[3], 8'hBC);
      check_eq("r12_hi_last", q12[12], 8'h0A);
      check_eq("r12_lo_last", q12[13], 8'hBC);
      check_eq("r12_sum", q12[14], 8'h00);
    end

    // Reset while sending word 2.
    pulse_tick();
    n = 0;
    while (!(rd_en && rd_addr == 2) && n < 200) begin
      step();
      n++;
    end
    check_eq("found_word2_fetch", rd_addr, 2);
    step();
    step();
    check_eq("in_send_valid", tx_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_tx_valid", tx_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_overruns", overruns, 0);
    check_eq("abort_rd_addr", rd_addr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    acc_log.delete();
    pulse_tick();
    n = 0;
    while (!rd_en && n < 50) begin
      step();
      n++;
    end
    check_eq("restart_rd_en", rd_en, 1);
    check_eq("restart_addr", rd_addr, 0);
    wait_idle(500);
    check_eq("restart_len", acc_log.size(), 15);
    if (acc_log.size() == 15) check_eq("restart_seq", acc_log[1], 8'h00);

    // Tick in the same cycle the checksum is accepted counts as an overrun.
    pulse_tick();
    n = 0;
    while (!(m_left == 1 && tx_valid) && n < 500) begin
      step();
      n++;
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_eq("edge_tick_overrun", overruns, 8'd1);
    check_eq("edge_tick_idle", busy, 0);
    s0 = snap_cnt;
    repeat (3) step();
    check_eq("edge_tick_no_snap", snap_cnt - s0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
